md_unit: RTL and testbench

- Execute-stage multiply/divide unit holding the architectural HI/LO registers.
- Consumes start, MD and MDCtrl from the main decoder (carried down the D/E pipeline registers).
- Runs mult/multu/div/divu over a fixed multi-cycle latency and services mfhi/mflo/mthi/mtlo.
- Drives busy, which the hazard unit uses to stall later MD-class instructions in D.

---
 rtl/md_unit.sv | 146 ++++++++++++++
 tb/tb_md_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Execute-stage multiply/divide unit owning the architectural HI/LO registers.
// Results are computed at start and committed after a fixed multi-cycle latency.
`timescale 1ns/1ps
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        MD,
    input  logic [3:0]  MDCtrl,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDout
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [31:0]        hi_reg, hi_next;
    logic [31:0]        lo_reg, lo_next;
    logic [31:0]        tmp_hi_reg, tmp_hi_next;
    logic [31:0]        tmp_lo_reg, tmp_lo_next;

    // Opcode bit 3 carries no meaning for this unit.
    logic unused_ctrl_bit;
    assign unused_ctrl_bit = MDCtrl[3];

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Shared magnitude divider; signs are restored afterwards so that the
    // 0x80000000 / -1 case wraps to 0x80000000 without special handling.
    logic        div_signed;
    logic        a_neg, b_neg;
    logic [31:0] div_a, div_b, div_b_safe;
    logic [31:0] quot_mag, rem_mag;
    logic [31:0] quot, rem;

    assign div_signed = ~MDCtrl[0];
    assign a_neg      = div_signed & A[31];
    assign b_neg      = div_signed & B[31];
    assign div_a      = a_neg ? (~A + 32'd1) : A;
    assign div_b      = b_neg ? (~B + 32'd1) : B;
    assign div_b_safe = (B == 32'd0) ? 32'd1 : div_b;
    assign quot_mag   = div_a / div_b_safe;
    assign rem_mag    = div_a % div_b_safe;
    assign quot       = (a_neg ^ b_neg) ? (~quot_mag + 32'd1) : quot_mag;
    assign rem        = a_neg ? (~rem_mag + 32'd1) : rem_mag;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        hi_next     = hi_reg;
        lo_next     = lo_reg;
        tmp_hi_next = tmp_hi_reg;
        tmp_lo_next = tmp_lo_reg;

        case (state_reg)
            IDLE: begin
                if (MD) begin
                    if (start && !MDCtrl[2]) begin
                        state_next = BUSY;
                        case (MDCtrl[1:0])
                            2'b00: begin
                                {tmp_hi_next, tmp_lo_next} = prod_s;
                                cnt_next = CNT_W'(MULT_CYCLES);
                            end
                            2'b01: begin
                                {tmp_hi_next, tmp_lo_next} = prod_u;
                                cnt_next = CNT_W'(MULT_CYCLES);
                            end
                            default: begin
                                // Divide by zero leaves HI/LO as they were.
                                if (B == 32'd0) begin
                                    tmp_hi_next = hi_reg;
                                    tmp_lo_next = lo_reg;
                                end else begin
                                    tmp_hi_next = rem;
                                    tmp_lo_next = quot;
                                end
                                cnt_next = CNT_W'(DIV_CYCLES);
                            end
                        endcase
                    end else if (!start && MDCtrl[2:0] == 3'b110) begin
                        hi_next = A;
                    end else if (!start && MDCtrl[2:0] == 3'b111) begin
                        lo_next = A;
                    end
                end
            end
            BUSY: begin
                if (cnt_reg == CNT_W'(1)) begin
                    hi_next    = tmp_hi_reg;
                    lo_next    = tmp_lo_reg;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            tmp_hi_reg <= '0;
            tmp_lo_reg <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            hi_reg     <= hi_next;
            lo_reg     <= lo_next;
            tmp_hi_reg <= tmp_hi_next;
            tmp_lo_reg <= tmp_lo_next;
        end
    end

    always_comb begin
        MDout = 32'd0;
        if (MD && MDCtrl[2:0] == 3'b100) MDout = hi_reg;
        else if (MD && MDCtrl[2:0] == 3'b101) MDout = lo_reg;
    end

    assign busy = (state_reg == BUSY);
    assign HI   = hi_reg;
    assign LO   = lo_reg;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit: arithmetic, latency, mt/mf,
// reset abort and ignored stray operations while busy.
`timescale 1ns/1ps
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        MD;
    logic [3:0]  MDCtrl;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDout;

    int pass_cnt  = 0;
    int total_cnt = 0;

    localparam logic [3:0] OP_MULT  = 4'b0000;
    localparam logic [3:0] OP_MULTU = 4'b0001;
    localparam logic [3:0] OP_DIV   = 4'b0010;
    localparam logic [3:0] OP_DIVU  = 4'b0011;
    localparam logic [3:0] OP_MFHI  = 4'b0100;
    localparam logic [3:0] OP_MFLO  = 4'b0101;
    localparam logic [3:0] OP_MTHI  = 4'b0110;
    localparam logic [3:0] OP_MTLO  = 4'b0111;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .MD     (MD),
        .MDCtrl (MDCtrl),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .HI     (HI),
        .LO     (LO),
        .MDout  (MDout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; everything is driven and sampled 1ns after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start  = 1'b0;
        MD     = 1'b0;
        MDCtrl = 4'b0000;
        A      = 32'd0;
        B      = 32'd0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        MD     = 1'b1;
        start  = (op[2] == 1'b0);
        MDCtrl = op;
        A      = a;
        B      = b;
        cyc();
        idle_inputs();
    endtask

    // Run an arithmetic op and verify busy length and the committed HI/LO.
    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int cycles,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL %s_busy_in_start_cycle: busy=%b expected 0", name, busy);
        else pass_cnt++;
        issue(op, a, b);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            cyc();
        end
        total_cnt++;
        if (n !== cycles) $display("FAIL %s_busy_len: got %0d cycles expected %0d", name, n, cycles);
        else pass_cnt++;
        total_cnt++;
        if (HI !== exp_hi || LO !== exp_lo)
            $display("FAIL %s_result: HI=%h LO=%h expected HI=%h LO=%h", name, HI, LO, exp_hi, exp_lo);
        else pass_cnt++;
        $display("op %s A=%h B=%h -> HI=%h LO=%h busy_cycles=%0d", name, a, b, HI, LO, n);
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        start  = 1'b1;
        MD     = 1'b1;
        MDCtrl = OP_MULT;
        A      = 32'h0000_0007;
        B      = 32'h0000_0009;
        for (int i = 0; i < 2; i++) begin
            cyc();
            total_cnt++;
            if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0)
                $display("FAIL reset_hold_%0d: busy=%b HI=%h LO=%h expected 0/0/0", i, busy, HI, LO);
            else pass_cnt++;
        end
        reset = 1'b1;
        idle_inputs();
        cyc();
        MD = 1'b1;
        MDCtrl = OP_MFLO;
        #1;
        total_cnt++;
        if (MDout !== 32'd0 || busy !== 1'b0)
            $display("FAIL reset_release: MDout=%h busy=%b expected 0/0", MDout, busy);
        else pass_cnt++;
        $display("reset: busy=%b HI=%h LO=%h MDout=%h", busy, HI, LO, MDout);
        idle_inputs();
    endtask

    task automatic test_mult();
        run_op("mult",  OP_MULT,  32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu", OP_MULTU, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA);
    endtask

    task automatic test_div();
        run_op("div",  OP_DIV,  32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu", OP_DIVU, 32'd7, 32'd2, 10, 32'h0000_0001, 32'h0000_0003);
        issue(OP_MTHI, 32'h11, 32'd0);
        issue(OP_MTLO, 32'h22, 32'd0);
        run_op("div_by_zero", OP_DIV, 32'd5, 32'd0, 10, 32'h0000_0011, 32'h0000_0022);
        run_op("div_overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
    endtask

    task automatic test_mt_mf();
        issue(OP_MTHI, 32'hDEAD_BEEF, 32'd0);
        issue(OP_MTLO, 32'h1234_5678, 32'd0);
        MD = 1'b1;
        MDCtrl = OP_MFHI;
        #1;
        total_cnt++;
        if (MDout !== 32'hDEAD_BEEF) $display("FAIL mfhi: MDout=%h expected deadbeef", MDout);
        else pass_cnt++;
        $display("mfhi -> MDout=%h", MDout);
        MDCtrl = OP_MFLO;
        #1;
        total_cnt++;
        if (MDout !== 32'h1234_5678) $display("FAIL mflo: MDout=%h expected 12345678", MDout);
        else pass_cnt++;
        $display("mflo -> MDout=%h", MDout);
        MD = 1'b0;
        MDCtrl = OP_MFHI;
        #1;
        total_cnt++;
        if (MDout !== 32'd0) $display("FAIL mf_without_md: MDout=%h expected 0", MDout);
        else pass_cnt++;
        // mthi with MD low must not write.
        MDCtrl = OP_MTHI;
        A = 32'hCAFE_F00D;
        cyc();
        idle_inputs();
        total_cnt++;
        if (HI !== 32'hDEAD_BEEF) $display("FAIL mt_without_md: HI=%h expected deadbeef", HI);
        else pass_cnt++;
        $display("mthi with MD=0 -> HI=%h", HI);
    endtask

    task automatic test_reset_abort();
        logic clean;
        issue(OP_MTHI, 32'h55, 32'd0);
        issue(OP_MULT, 32'd2, 32'd3);
        cyc();
        cyc();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        total_cnt++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0)
            $display("FAIL abort_reset: busy=%b HI=%h LO=%h expected 0/0/0", busy, HI, LO);
        else pass_cnt++;
        clean = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) clean = 1'b0;
        end
        total_cnt++;
        if (clean !== 1'b1) $display("FAIL abort_late_update: busy=%b HI=%h LO=%h expected 0/0/0", busy, HI, LO);
        else pass_cnt++;
        $display("reset abort: busy=%b HI=%h LO=%h", busy, HI, LO);
    endtask

    task automatic test_back_to_back();
        int n;
        issue(OP_MTLO, 32'h77, 32'd0);
        issue(OP_DIV, 32'd100, 32'd7);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            if (n == 1) begin
                MD = 1'b1; start = 1'b0; MDCtrl = OP_MTLO; A = 32'h0000_0BAD;
            end else if (n == 2) begin
                total_cnt++;
                if (LO !== 32'h77) $display("FAIL busy_mtlo_ignored: LO=%h expected 00000077", LO);
                else pass_cnt++;
                MD = 1'b1; start = 1'b1; MDCtrl = OP_MULT; A = 32'd3; B = 32'd3;
            end else begin
                idle_inputs();
            end
            n++;
            cyc();
        end
        idle_inputs();
        total_cnt++;
        if (n !== 10) $display("FAIL busy_no_extend: got %0d cycles expected 10", n);
        else pass_cnt++;
        total_cnt++;
        if (HI !== 32'd2 || LO !== 32'd14)
            $display("FAIL busy_first_result: HI=%h LO=%h expected 00000002/0000000e", HI, LO);
        else pass_cnt++;
        cyc();
        total_cnt++;
        if (busy !== 1'b0 || HI !== 32'd2 || LO !== 32'd14)
            $display("FAIL busy_after_done: busy=%b HI=%h LO=%h expected 0/2/e", busy, HI, LO);
        else pass_cnt++;
        $display("div with stray ops: busy_cycles=%0d HI=%h LO=%h", n, HI, LO);
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        #1;
        test_reset();
        test_mult();
        test_div();
        test_mt_mf();
        test_reset_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
